// File: rtl/top.sv
// BCD 24-hour clock multiplexed onto a 4x4 LED matrix (row scan, digit columns).
// Define FAST_SIM_EN for a 16-cycle minute and a one-cycle row period.
module top #(
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic       clk,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    input  logic       rst_n,
    output logic [3:0] row
);

`ifdef FAST_SIM_EN
    localparam int unsigned T_CYC  = 16;
    localparam int unsigned SCAN_N = 1;
`else
    localparam int unsigned T_CYC  = CLK_HZ * 60;
    localparam int unsigned SCAN_N = SCAN_DIV;
`endif
    localparam int unsigned PW = (T_CYC > 1) ? $clog2(T_CYC) : 1;
    localparam int unsigned SW = (SCAN_N > 1) ? $clog2(SCAN_N) : 1;

    // Power-up values equal reset values so an undriven rst_n still runs.
    logic [PW-1:0] pre_q  = '0;
    logic [SW-1:0] scan_q = '0;
    logic [1:0]    sel_q  = '0;
    logic [3:0]    m0_q   = '0;
    logic [2:0]    m1_q   = '0;
    logic [3:0]    h0_q   = '0;
    logic [1:0]    h1_q   = '0;
    logic [3:0]    row_q  = 4'b0001;
    logic [3:0]    led_q  = '0;

    logic [PW-1:0] pre_d;
    logic [SW-1:0] scan_d;
    logic [1:0]    sel_d;
    logic [3:0]    m0_d;
    logic [2:0]    m1_d;
    logic [3:0]    h0_d;
    logic [1:0]    h1_d;
    logic [3:0]    row_d;
    logic [3:0]    led_d;
    logic          tick;
    logic          scan_wrap;
    logic [3:0]    h1_v;
    logic [3:0]    m1_v;

    always_comb begin
        tick  = (pre_q == PW'(T_CYC - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
        m0_d  = m0_q;
        m1_d  = m1_q;
        h0_d  = h0_q;
        h1_d  = h1_q;
        if (tick) begin
            if (m0_q != 4'd9) begin
                m0_d = m0_q + 4'd1;
            end else begin
                m0_d = '0;
                if (m1_q != 3'd5) begin
                    m1_d = m1_q + 3'd1;
                end else begin
                    m1_d = '0;
                    if (h1_q == 2'd2 && h0_q == 4'd3) begin
                        h0_d = '0;
                        h1_d = '0;
                    end else if (h0_q == 4'd9) begin
                        h0_d = '0;
                        h1_d = h1_q + 2'd1;
                    end else begin
                        h0_d = h0_q + 4'd1;
                    end
                end
            end
        end
    end

    // Row and columns both derive from sel_q, so they always match.
    always_comb begin
        scan_wrap = (scan_q == SW'(SCAN_N - 1));
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        sel_d     = scan_wrap ? sel_q + 2'd1 : sel_q;
        h1_v      = {2'b00, h1_q};
        m1_v      = {1'b0, m1_q};
        row_d     = 4'b0001 << sel_q;
        led_d     = {h1_v[sel_q], h0_q[sel_q], m1_v[sel_q], m0_q[sel_q]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            scan_q <= '0;
            sel_q  <= '0;
            m0_q   <= '0;
            m1_q   <= '0;
            h0_q   <= '0;
            h1_q   <= '0;
            row_q  <= 4'b0001;
            led_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            scan_q <= scan_d;
            sel_q  <= sel_d;
            m0_q   <= m0_d;
            m1_q   <= m1_d;
            h0_q   <= h0_d;
            h1_q   <= h1_d;
            row_q  <= row_d;
            led_q  <= led_d;
        end
    end

    assign row  = row_q;
    assign led1 = led_q[3];
    assign led2 = led_q[2];
    assign led3 = led_q[1];
    assign led4 = led_q[0];

endmodule

// File: tb/tb_top.sv
// Directed bench for the LED matrix clock: reset, scan order, minute timing,
// minute/hour carries, day wrap and mid-count reset.
module tb_top;

`ifdef FAST_SIM_EN
    localparam int T = 16;
`else
    localparam int T = 60;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       led1, led2, led3, led4;
    logic [3:0] row;
    logic [3:0] leds;

    int vectors = 0;
    int errors  = 0;
    int n       = 0;

    top #(.CLK_HZ(1), .SCAN_DIV(1)) dut (
        .clk  (clk),
        .led1 (led1),
        .led2 (led2),
        .led3 (led3),
        .led4 (led4),
        .rst_n(rst_n),
        .row  (row)
    );

    always #5 clk = ~clk;

    assign leds = {led1, led2, led3, led4};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int e);
        while (n < e) step();
    endtask

    // Expected columns for row k at absolute minute count mins.
    function automatic logic [3:0] exp_leds(input int mins, input int k);
        int hh, mm;
        logic [3:0] h1, h0, m1, m0;
        hh = (mins / 60) % 24;
        mm = mins % 60;
        h1 = 4'(hh / 10);
        h0 = 4'(hh % 10);
        m1 = 4'(mm / 10);
        m0 = 4'(mm % 10);
        return {h1[k], h0[k], m1[k], m0[k]};
    endfunction

    // Scan all four rows while the displayed minute is stable.
    task automatic check_time(input string tag, input int mins);
        int k;
        run_to(mins * T + 4);
        for (int i = 0; i < 4; i++) begin
            step();
            k = (n - 1) % 4;
            check({tag, "_row"}, 32'(row), 32'(4'b0001 << k));
            check({tag, "_leds"}, 32'(leds), 32'(exp_leds(mins, k)));
        end
    endtask

    initial begin
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n = 1'b0;
        step();
        step();
        check("rst_row", 32'(row), 32'h1);
        check("rst_leds", 32'(leds), 32'h0);
        rst_n = 1'b1;
        n = 0;

        for (int i = 0; i < 5; i++) begin
            step();
            check("scan_seq", 32'(row), 32'(seq[i]));
        end

        run_to(T - 3);
        check("pre_tick_row", 32'(row), 32'h1);
        check("pre_tick_m0", 32'(led4), 32'h0);
        run_to(T + 1);
        check("post_tick_row", 32'(row), 32'h1);
        check("post_tick_m0", 32'(led4), 32'h1);

        check_time("t0005", 5);
        check_time("t0007", 7);

        run_to(7 * T + T / 2);
        rst_n = 1'b0;
        step();
        check("midrst_row", 32'(row), 32'h1);
        check("midrst_leds", 32'(leds), 32'h0);
        rst_n = 1'b1;
        n = 0;

        check_time("t0000_after_rst", 0);
        run_to(T - 3);
        check("rst_pre_tick_m0", 32'(led4), 32'h0);
        run_to(T + 1);
        check("rst_post_tick_m0", 32'(led4), 32'h1);

        check_time("t0010", 10);
        check_time("t0100", 60);
        check_time("t2359", 1439);
        check_time("t0000_wrap", 1440);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
